bp_me_dram_hash_decode: RTL and testbench

BP_ME_DRAM_HASH_DECODE -- requirements
Module: bp_me_dram_hash_decode

---
 rtl/bp_me_pkg.sv | 94 +++++++++
 rtl/bp_me_dram_hash_unswizzle.sv | 21 ++
 rtl/bp_me_dram_hash_decode.sv | 104 ++++++++++
 tb/tb_bp_me_dram_hash_decode.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - processor configurations and DRAM hash field derivations shared by encode/decode
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg,
        e_bp_unicore_cfg
    } bp_params_e;

    typedef struct packed {
        int num_cce;
        int l2_slices;
        int l2_banks;
        int l2_sets;
        int l2_block_width;
        int daddr_width;
        int paddr_width;
        int l2_data_width;
    } bp_proc_param_s;

    function automatic bp_proc_param_s bp_get_cfg(input bp_params_e p);
        bp_proc_param_s c;
        c.num_cce        = 2;
        c.l2_slices      = 2;
        c.l2_banks       = 2;
        c.l2_sets        = 64;
        c.l2_block_width = 512;
        c.daddr_width    = 32;
        c.paddr_width    = 40;
        c.l2_data_width  = 64;
        if (p == e_bp_unicore_cfg) begin
            c.num_cce   = 1;
            c.l2_slices = 1;
            c.l2_banks  = 1;
        end
        return c;
    endfunction

    // A field that selects among a single item occupies no address bits.
    function automatic int lg_or_zero(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int bp_block_w(input bp_proc_param_s c);
        return lg_or_zero(c.l2_block_width / 8);
    endfunction

    function automatic int bp_set_w(input bp_proc_param_s c);
        return lg_or_zero(c.l2_sets);
    endfunction

    function automatic int bp_cce_w(input bp_proc_param_s c);
        return lg_or_zero(c.num_cce);
    endfunction

    function automatic int bp_slice_w(input bp_proc_param_s c);
        return lg_or_zero(c.l2_slices);
    endfunction

    function automatic int bp_bank_w(input bp_proc_param_s c);
        return lg_or_zero(c.l2_banks);
    endfunction

    function automatic int bp_tag_w(input bp_proc_param_s c);
        return c.daddr_width - bp_block_w(c) - bp_set_w(c) - bp_cce_w(c)
               - bp_slice_w(c) - bp_bank_w(c);
    endfunction

    // Encoded (DRAM) layout, LSB first: block, set, cce, slice, bank, tag.
    function automatic int bp_enc_slice_off(input bp_proc_param_s c);
        return bp_block_w(c) + bp_set_w(c) + bp_cce_w(c);
    endfunction

    function automatic int bp_enc_bank_off(input bp_proc_param_s c);
        return bp_enc_slice_off(c) + bp_slice_w(c);
    endfunction

    // Physical layout, LSB first: block, cce, slice, bank, set, tag.
    // Returns the encoded bit position feeding physical bit i.
    function automatic int bp_dram_src_bit(input bp_proc_param_s c, input int i);
        int bw, sw, cw, lw, kw;
        bw = bp_block_w(c);
        sw = bp_set_w(c);
        cw = bp_cce_w(c);
        lw = bp_slice_w(c);
        kw = bp_bank_w(c);
        if (i < bw)                     return i;
        if (i < bw + cw)                return i + sw;
        if (i < bw + cw + lw)           return i + sw;
        if (i < bw + cw + lw + kw)      return i + sw;
        if (i < bw + cw + lw + kw + sw) return i - (cw + lw + kw);
        return i;
    endfunction

endpackage

// File: rtl/bp_me_dram_hash_unswizzle.sv
// rtl/bp_me_dram_hash_unswizzle.sv - combinational DRAM-to-physical address field reorder
module bp_me_dram_hash_unswizzle
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam bp_proc_param_s cfg_lp = bp_get_cfg(bp_params_p),
    localparam int daddr_width_p = cfg_lp.daddr_width,
    localparam int paddr_width_p = cfg_lp.paddr_width
) (
    input  logic [daddr_width_p-1:0] daddr_i,
    output logic [paddr_width_p-1:0] paddr_o
);

    always_comb begin
        paddr_o = '0;
        for (int i = 0; i < daddr_width_p; i++) begin
            paddr_o[i] = daddr_i[bp_dram_src_bit(cfg_lp, i)];
        end
    end

endmodule

// File: rtl/bp_me_dram_hash_decode.sv
// rtl/bp_me_dram_hash_decode.sv - unswizzle hashed DRAM addresses into a 2-entry response FIFO
module bp_me_dram_hash_decode
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam bp_proc_param_s cfg_lp = bp_get_cfg(bp_params_p),
    localparam int daddr_width_p   = cfg_lp.daddr_width,
    localparam int paddr_width_p   = cfg_lp.paddr_width,
    localparam int l2_data_width_p = cfg_lp.l2_data_width,
    localparam int slice_id_w_lp   = (bp_slice_w(cfg_lp) > 0) ? bp_slice_w(cfg_lp) : 1,
    localparam int bank_id_w_lp    = (bp_bank_w(cfg_lp) > 0) ? bp_bank_w(cfg_lp) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    output logic                       ready_and_o,
    input  logic [daddr_width_p-1:0]   daddr_i,
    input  logic [slice_id_w_lp-1:0]   slice_i,
    input  logic [bank_id_w_lp-1:0]    bank_i,
    input  logic [l2_data_width_p-1:0] data_i,
    output logic                       v_o,
    input  logic                       ready_and_i,
    output logic [paddr_width_p-1:0]   paddr_o,
    output logic [l2_data_width_p-1:0] data_o,
    output logic                       error_o
);

    localparam int slice_off_lp = bp_enc_slice_off(cfg_lp);
    localparam int bank_off_lp  = bp_enc_bank_off(cfg_lp);

    logic [paddr_width_p-1:0]   paddr_dec;
    logic                       enq, deq, mismatch;
    logic [1:0]                 count_q, count_d;
    logic                       wptr_q, wptr_d, rptr_q, rptr_d;
    logic                       error_q, error_d;
    logic [paddr_width_p-1:0]   paddr_mem_q [2];
    logic [paddr_width_p-1:0]   paddr_mem_d [2];
    logic [l2_data_width_p-1:0] data_mem_q  [2];
    logic [l2_data_width_p-1:0] data_mem_d  [2];

    bp_me_dram_hash_unswizzle #(
        .bp_params_p(bp_params_p)
    ) u_unswizzle (
        .daddr_i(daddr_i),
        .paddr_o(paddr_dec)
    );

    // Only fields that actually exist in the address can disagree with the sideband ids.
    always_comb begin
        mismatch = 1'b0;
        if (cfg_lp.l2_slices > 1) begin
            for (int k = 0; k < slice_id_w_lp; k++) begin
                if (daddr_i[slice_off_lp + k] != slice_i[k]) mismatch = 1'b1;
            end
        end
        if (cfg_lp.l2_banks > 1) begin
            for (int k = 0; k < bank_id_w_lp; k++) begin
                if (daddr_i[bank_off_lp + k] != bank_i[k]) mismatch = 1'b1;
            end
        end
    end

    assign ready_and_o = (count_q != 2'd2);
    assign v_o         = (count_q != 2'd0);
    assign paddr_o     = paddr_mem_q[rptr_q];
    assign data_o      = data_mem_q[rptr_q];
    assign error_o     = error_q;

    always_comb begin
        enq         = v_i & ready_and_o;
        deq         = v_o & ready_and_i;
        count_d     = count_q + {1'b0, enq} - {1'b0, deq};
        wptr_d      = wptr_q ^ enq;
        rptr_d      = rptr_q ^ deq;
        error_d     = error_q | (enq & mismatch);
        paddr_mem_d = paddr_mem_q;
        data_mem_d  = data_mem_q;
        if (enq) begin
            paddr_mem_d[wptr_q] = paddr_dec;
            data_mem_d[wptr_q]  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            error_q <= error_d;
        end
    end

    // Payload storage is qualified by count, so it carries no reset.
    always_ff @(posedge clk_i) begin
        paddr_mem_q <= paddr_mem_d;
        data_mem_q  <= data_mem_d;
    end

endmodule

// File: tb/tb_bp_me_dram_hash_decode.sv
// tb/tb_bp_me_dram_hash_decode.sv - self-checking bench for bp_me_dram_hash_decode
module tb_bp_me_dram_hash_decode;
    import bp_me_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i, ready_and_o, v_o, ready_and_i, error_o;
    logic [31:0] daddr_i;
    logic [0:0]  slice_i, bank_i;
    logic [63:0] data_i, data_o;
    logic [39:0] paddr_o;

    always #5 clk_i = ~clk_i;

    bp_me_dram_hash_decode #(
        .bp_params_p(e_bp_default_cfg)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .v_i(v_i),
        .ready_and_o(ready_and_o),
        .daddr_i(daddr_i),
        .slice_i(slice_i),
        .bank_i(bank_i),
        .data_i(data_i),
        .v_o(v_o),
        .ready_and_i(ready_and_i),
        .paddr_o(paddr_o),
        .data_o(data_o),
        .error_o(error_o)
    );

    typedef struct {
        logic [31:0] daddr;
        logic [63:0] data;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    outs   = 0;
    logic  exp_err;

    // 64B block, 64 sets, 2 CCE, 2 slices, 2 banks.
    function automatic logic [39:0] ref_decode(input logic [31:0] d);
        logic [39:0] blk, set, cce, slc, bnk, tag;
        blk = 40'(d % 64);
        set = 40'((d / 64) % 64);
        cce = 40'((d / 4096) % 2);
        slc = 40'((d / 8192) % 2);
        bnk = 40'((d / 16384) % 2);
        tag = 40'(d / 32768);
        return blk + cce * 64 + slc * 128 + bnk * 256 + set * 512 + tag * 32768;
    endfunction

    function automatic logic [31:0] ref_encode(input logic [39:0] p);
        logic [39:0] blk, set, cce, slc, bnk, tag;
        blk = p % 64;
        cce = (p / 64) % 2;
        slc = (p / 128) % 2;
        bnk = (p / 256) % 2;
        set = (p / 512) % 64;
        tag = p / 32768;
        return 32'(blk + set * 64 + cce * 4096 + slc * 8192 + bnk * 16384 + tag * 32768);
    endfunction

    function automatic logic ref_mismatch(input logic [31:0] d, input logic s, input logic b);
        return (((d / 8192) % 2) != 32'(s)) || (((d / 16384) % 2) != 32'(b));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic b,
                         input logic rdy);
        v_i         = v;
        daddr_i     = d;
        slice_i     = s;
        bank_i      = b;
        ready_and_i = rdy;
        data_i      = {$urandom, $urandom};
    endtask

    task automatic step();
        logic  acc_in, acc_out, set_err;
        beat_t b;
        chk("ready_and_o", 64'(ready_and_o), 64'(q.size() < 2));
        chk("v_o", 64'(v_o), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("paddr_o", 64'(paddr_o), 64'(ref_decode(q[0].daddr)));
            chk("data_o", data_o, q[0].data);
            chk("roundtrip", 64'(ref_encode(paddr_o)), 64'(q[0].daddr));
        end
        chk("error_o", 64'(error_o), 64'(exp_err));
        acc_in  = v_i && (q.size() < 2);
        acc_out = (q.size() > 0) && ready_and_i;
        set_err = acc_in && ref_mismatch(daddr_i, slice_i, bank_i);
        b.daddr = daddr_i;
        b.data  = data_i;
        @(posedge clk_i);
        #1;
        if (acc_out) begin
            void'(q.pop_front());
            outs++;
        end
        if (acc_in) q.push_back(b);
        if (set_err) exp_err = 1'b1;
    endtask

    initial begin
        exp_err   = 1'b0;
        reset_n_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("reset_v_o", 64'(v_o), 64'd0);
        chk("reset_ready", 64'(ready_and_o), 64'd1);
        chk("reset_error", 64'(error_o), 64'd0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        step();

        drive(1'b1, 32'h1040, 1'b0, 1'b0, 1'b1);
        step();
        chk("basic_paddr", 64'(paddr_o), 64'h240);
        chk("basic_v_o", 64'(v_o), 64'd1);
        drive(1'b1, 32'h4000, 1'b0, 1'b1, 1'b1);
        step();
        chk("bank_paddr", 64'(paddr_o), 64'h100);
        chk("bank_error", 64'(error_o), 64'd0);
        drive(1'b1, 32'h4000, 1'b0, 1'b0, 1'b1);
        step();
        chk("mismatch_error", 64'(error_o), 64'd1);
        chk("mismatch_fwd", 64'(paddr_o), 64'h100);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("error_sticky", 64'(error_o), 64'd1);

        drive(1'b1, 32'h1040, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h4000, 1'b0, 1'b1, 1'b0);
        step();
        chk("stall_full", 64'(ready_and_o), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk("stall_head", 64'(paddr_o), 64'h240);
        ready_and_i = 1'b1;
        step();
        chk("drain_second", 64'(paddr_o), 64'h100);
        step();
        step();

        for (int i = 0; i < 2000; i++) begin
            drive(1'b1, $urandom, 1'($urandom), 1'($urandom), 1'b1);
            step();
        end
        chk("stream_rate", 64'(outs > 2000 + 3), 64'd1);
        for (int i = 0; i < 8000; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            step();
        end

        drive(1'b1, 32'h1040, 1'b0, 1'b1, 1'b0);
        step();
        step();
        step();
        chk("pre_reset_full", 64'(ready_and_o), 64'd0);
        #3;
        reset_n_i = 1'b0;
        #1;
        chk("async_v_o", 64'(v_o), 64'd0);
        chk("async_ready", 64'(ready_and_o), 64'd1);
        chk("async_error", 64'(error_o), 64'd0);
        q.delete();
        exp_err = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        drive(1'b1, 32'h2000, 1'b1, 1'b0, 1'b1);
        step();
        chk("post_reset_paddr", 64'(paddr_o), 64'h80);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
